seq_rotl_unit: RTL and testbench

- Multicycle left-direction shift/rotate unit: rotate-left (ROL) or logical shift-left (SLL) of a 16-bit operand by a 4-bit count.
- Moves one bit position per clock.
- Sits beside the combinational right rotator in the execute stage. Used for left-direction ops where area matters more than latency.
- Valid/ready handshake on both input and output sides.

---
 rtl/seq_rotl_unit_if.sv | 27 ++
 rtl/seq_rotl_unit.sv | 91 +++++++++
 tb/tb_seq_rotl_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/seq_rotl_unit_if.sv
// Request/response bundle for the multicycle left shift/rotate unit.
// The slave modport is the unit; the master modport is the requester/consumer side.
interface seq_rotl_unit_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] In;
  logic [CNT_W-1:0] Cnt;
  logic             Op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Out;
  logic             Cout;
  logic             busy;

  modport master (
    output in_valid, In, Cnt, Op, out_ready,
    input  in_ready, out_valid, Out, Cout, busy
  );

  modport slave (
    input  in_valid, In, Cnt, Op, out_ready,
    output in_ready, out_valid, Out, Cout, busy
  );
endinterface

// File: rtl/seq_rotl_unit.sv
// Bit-serial rotate-left / logical shift-left: one bit position per clock,
// with valid/ready on both sides and one operation in flight at a time.
module seq_rotl_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_rotl_unit_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_next;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] w_rem_next;
  logic             r_op;
  logic             w_op_next;
  logic             r_cout;
  logic             w_cout_next;
  logic             w_fill;

  // SLL feeds a zero into bit 0; ROL feeds back the bit leaving the top.
  assign w_fill = r_op ? 1'b0 : r_data[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_rem   <= '0;
      r_op    <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_data  <= w_data_next;
      r_rem   <= w_rem_next;
      r_op    <= w_op_next;
      r_cout  <= w_cout_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_data_next  = r_data;
    w_rem_next   = r_rem;
    w_op_next    = r_op;
    w_cout_next  = r_cout;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_data_next  = bus.In;
          w_rem_next   = bus.Cnt;
          w_op_next    = bus.Op;
          w_cout_next  = 1'b0;
          w_state_next = (bus.Cnt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        w_cout_next = r_data[WIDTH-1];
        w_data_next = {r_data[WIDTH-2:0], w_fill};
        w_rem_next  = r_rem - CNT_W'(1);
        if (r_rem == CNT_W'(1)) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        // Result and carry stay put after the handshake, only the state moves.
        if (bus.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.Out       = r_data;
  assign bus.Cout      = r_cout;

endmodule

// File: tb/tb_seq_rotl_unit.sv
// Scoreboard bench for seq_rotl_unit: the driver queues hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_seq_rotl_unit;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [WIDTH-1:0] out;
    logic             cout;
  } exp_t;

  typedef struct packed {
    logic [WIDTH-1:0] in;
    logic [CNT_W-1:0] cnt;
    logic             op;
    logic [WIDTH-1:0] out;
    logic             cout;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   txn;
  exp_t exp_q[$];

  seq_rotl_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  seq_rotl_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: one line per completed output transaction.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(bus.Out), 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d: Out=0x%04h Cout=%0b (expected Out=0x%04h Cout=%0b)",
                 txn, bus.Out, bus.Cout, e.out, e.cout);
        check("out", 32'(bus.Out), 32'(e.out));
        check("cout", 32'(bus.Cout), 32'(e.cout));
      end
    end
  end

  // Accept one request and measure edges from acceptance until out_valid.
  task automatic run_op(input vec_t v);
    int k;
    k = 0;
    while (!bus.in_ready && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("in_ready_before_issue", 32'(bus.in_ready), 32'd1);
    exp_q.push_back('{out: v.out, cout: v.cout});
    bus.in_valid = 1'b1;
    bus.In       = v.in;
    bus.Cnt      = v.cnt;
    bus.Op       = v.op;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.In       = 16'h5A5A;
    bus.Cnt      = 4'hF;
    bus.Op       = ~v.op;
    k = 0;
    while (!bus.out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("latency", 32'(k), 32'(v.cnt));
    if (!bus.out_valid) exp_q.delete();
  endtask

  vec_t vecs[6];

  initial begin
    errors = 0;
    checks = 0;
    txn    = 0;
    rst_n  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.In        = '0;
    bus.Cnt       = '0;
    bus.Op        = 1'b0;
    bus.out_ready = 1'b1;

    #12;
    check("rst_out", 32'(bus.Out), 32'h0);
    check("rst_cout", 32'(bus.Cout), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    //          in       cnt  op    out      cout
    vecs[0] = '{16'h8001, 4'd1,  1'b0, 16'h0003, 1'b1};
    vecs[1] = '{16'h8001, 4'd4,  1'b1, 16'h0010, 1'b0};
    vecs[2] = '{16'h1234, 4'd8,  1'b0, 16'h3412, 1'b0};
    vecs[3] = '{16'hFFFE, 4'd15, 1'b1, 16'h0000, 1'b1};
    vecs[4] = '{16'hABCD, 4'd0,  1'b0, 16'hABCD, 1'b0};
    vecs[5] = '{16'h8000, 4'd15, 1'b0, 16'h4000, 1'b0};

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i]);
      @(posedge clk); #1;
      check("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
      check("out_valid_after_hs", 32'(bus.out_valid), 32'd0);
    end

    // Backpressure with an intruding request that must be ignored.
    bus.out_ready = 1'b0;
    run_op('{16'h00F0, 4'd3, 1'b1, 16'h0780, 1'b0});
    bus.in_valid = 1'b1;
    bus.In       = 16'h5555;
    bus.Cnt      = 4'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out", 32'(bus.Out), 32'h0780);
      check("bp_cout", 32'(bus.Cout), 32'h0);
      check("bp_in_ready", 32'(bus.in_ready), 32'h0);
      check("bp_busy", 32'(bus.busy), 32'h1);
      check("bp_out_valid", 32'(bus.out_valid), 32'h1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_in_ready", 32'(bus.in_ready), 32'h1);
    check("bp_retained_out", 32'(bus.Out), 32'h0780);
    @(posedge clk); #1;
    check("bp_idle_busy", 32'(bus.busy), 32'h0);

    // Reset in the middle of a 10-step rotate aborts it with no result.
    bus.in_valid = 1'b1;
    bus.In       = 16'h00FF;
    bus.Cnt      = 4'd10;
    bus.Op       = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("mid_busy", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_out", 32'(bus.Out), 32'h0);
    check("abort_cout", 32'(bus.Cout), 32'h0);
    check("abort_out_valid", 32'(bus.out_valid), 32'h0);
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op('{16'h0001, 4'd2, 1'b0, 16'h0004, 1'b0});
    @(posedge clk); #1;
    @(posedge clk); #1;

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("txn_count", 32'(txn), 32'd8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
